// File: rtl/data_mem_dp.sv
// Two-port data memory: one write port, one independent read port, hardware clear after reset.
// Read latency is 0 (combinational) or 1 (registered, write-first on address collision).
module data_mem_dp #(
   parameter int             W        = 8,
   parameter int             A        = 8,
   parameter int             RD_LAT   = 1,
   parameter logic [W-1:0]   INIT_VAL = '0
) (
   input  logic         Clk,
   input  logic         Reset,
   output logic         Ready,
   input  logic         WriteEn,
   input  logic [A-1:0] WrAddr,
   input  logic [W-1:0] WrData,
   input  logic         RdEn,
   input  logic [A-1:0] RdAddr,
   output logic [W-1:0] RdData,
   output logic         RdValid
);

   localparam int DEPTH = 1 << A;

   typedef enum logic {
      ST_CLEAR = 1'b0,
      ST_RUN   = 1'b1
   } state_t;

   state_t         state_q, state_d;
   logic [A:0]     clr_ptr_q, clr_ptr_d;

   logic           mem_we;
   logic [A-1:0]   mem_addr;
   logic [W-1:0]   mem_dat;
   logic           rd_fire;

   logic [W-1:0]   Core [DEPTH];

   always_ff @(posedge Clk) begin
      if (Reset) begin
         state_q   <= ST_CLEAR;
         clr_ptr_q <= '0;
      end else begin
         state_q   <= state_d;
         clr_ptr_q <= clr_ptr_d;
      end
   end

   // The clear engine owns the single write port until the last word is written;
   // the carry into bit A of the pointer marks that last step.
   always_comb begin
      state_d   = state_q;
      clr_ptr_d = clr_ptr_q;
      mem_we    = 1'b0;
      mem_addr  = WrAddr;
      mem_dat   = WrData;
      case (state_q)
         ST_CLEAR: begin
            mem_we    = 1'b1;
            mem_addr  = clr_ptr_q[A-1:0];
            mem_dat   = INIT_VAL;
            clr_ptr_d = clr_ptr_q + 1'b1;
            if (clr_ptr_d[A]) begin
               state_d = ST_RUN;
            end
         end
         ST_RUN: begin
            mem_we = WriteEn;
         end
         default: begin
            state_d = ST_CLEAR;
         end
      endcase
      if (Reset) begin
         mem_we = 1'b0;
      end
   end

   always_ff @(posedge Clk) begin
      if (mem_we) begin
         Core[mem_addr] <= mem_dat;
      end
   end

   assign Ready   = (state_q == ST_RUN);
   assign rd_fire = RdEn & Ready;

   generate
      if (RD_LAT == 0) begin : g_comb_rd
         assign RdData  = Core[RdAddr];
         assign RdValid = rd_fire;
      end else begin : g_reg_rd
         logic [W-1:0] rd_data_q, rd_data_d;
         logic         rd_valid_q;

         // Same-edge write to the read address forwards the new data.
         always_comb begin
            rd_data_d = rd_data_q;
            if (rd_fire) begin
               if (WriteEn && (WrAddr == RdAddr)) begin
                  rd_data_d = WrData;
               end else begin
                  rd_data_d = Core[RdAddr];
               end
            end
         end

         always_ff @(posedge Clk) begin
            if (Reset) begin
               rd_data_q  <= '0;
               rd_valid_q <= 1'b0;
            end else begin
               rd_data_q  <= rd_data_d;
               rd_valid_q <= rd_fire;
            end
         end

         assign RdData  = rd_data_q;
         assign RdValid = rd_valid_q;
      end
   endgenerate

endmodule

// File: tb/tb_data_mem_dp.sv
// Bench for data_mem_dp: one registered-read and one combinational-read instance share stimulus,
// compared against an array/counter reference model.
module tb_data_mem_dp;

   logic       Clk = 1'b0;
   logic       Reset = 1'b1;
   logic       WriteEn = 1'b0;
   logic [3:0] WrAddr = '0;
   logic [7:0] WrData = '0;
   logic       RdEn = 1'b0;
   logic [3:0] RdAddr = '0;

   logic       rdy1, rdv1, rdy0, rdv0;
   logic [7:0] rdd1, rdd0;

   int n_total = 0;
   int n_bad   = 0;

   // reference model: contents, cycles since reset release, registered-read outputs
   logic [7:0] m_mem [16];
   int         m_cyc = 0;
   logic       m_v1 = 1'b0;
   logic [7:0] m_d1 = 8'h00;

   always #5 Clk = ~Clk;

   data_mem_dp #(.W(8), .A(4), .RD_LAT(1), .INIT_VAL(8'hA5)) u_dut1 (
      .Clk(Clk), .Reset(Reset), .Ready(rdy1),
      .WriteEn(WriteEn), .WrAddr(WrAddr), .WrData(WrData),
      .RdEn(RdEn), .RdAddr(RdAddr), .RdData(rdd1), .RdValid(rdv1)
   );

   data_mem_dp #(.W(8), .A(4), .RD_LAT(0), .INIT_VAL(8'hA5)) u_dut0 (
      .Clk(Clk), .Reset(Reset), .Ready(rdy0),
      .WriteEn(WriteEn), .WrAddr(WrAddr), .WrData(WrData),
      .RdEn(RdEn), .RdAddr(RdAddr), .RdData(rdd0), .RdValid(rdv0)
   );

   task automatic drive(input logic r, input logic we, input logic [3:0] wa, input logic [7:0] wd,
                        input logic re, input logic [3:0] ra);
      Reset = r; WriteEn = we; WrAddr = wa; WrData = wd; RdEn = re; RdAddr = ra;
   endtask

   // Advance one clock edge and apply the same edge to the model.
   task automatic tick();
      logic rdy;
      @(posedge Clk);
      rdy = (m_cyc >= 16);
      if (Reset) begin
         m_v1 = 1'b0; m_d1 = 8'h00; m_cyc = 0;
      end else begin
         if (rdy && RdEn) begin
            m_v1 = 1'b1;
            m_d1 = (WriteEn && WrAddr == RdAddr) ? WrData : m_mem[RdAddr];
         end else begin
            m_v1 = 1'b0;
         end
         if (rdy && WriteEn) m_mem[WrAddr] = WrData;
         if (m_cyc < 16) begin
            m_cyc++;
            if (m_cyc == 16) for (int i = 0; i < 16; i++) m_mem[i] = 8'hA5;
         end
      end
      #1;
   endtask

   task automatic test_reset();
      drive(1, 0, 0, 0, 0, 0); tick(); tick();
      @(negedge Clk);
      n_total++; if (rdy1 !== 1'b0) begin n_bad++; $display("FAIL reset_ready1 got=%b exp=0", rdy1); end
      n_total++; if (rdy0 !== 1'b0) begin n_bad++; $display("FAIL reset_ready0 got=%b exp=0", rdy0); end
      n_total++; if (rdv1 !== 1'b0) begin n_bad++; $display("FAIL reset_rdvalid1 got=%b exp=0", rdv1); end
      n_total++; if (rdd1 !== 8'h00) begin n_bad++; $display("FAIL reset_rddata1 got=%h exp=00", rdd1); end
      n_total++; if (rdv0 !== 1'b0) begin n_bad++; $display("FAIL reset_rdvalid0 got=%b exp=0", rdv0); end
      tick();
      for (int k = 0; k <= 16; k++) begin
         drive(0, 0, 0, 0, 0, 0);
         @(negedge Clk);
         n_total++; if (rdy1 !== (k >= 16)) begin n_bad++; $display("FAIL clear_ready1 cyc=%0d got=%b exp=%b", k, rdy1, (k >= 16)); end
         n_total++; if (rdy0 !== (k >= 16)) begin n_bad++; $display("FAIL clear_ready0 cyc=%0d got=%b exp=%b", k, rdy0, (k >= 16)); end
         tick();
      end
      for (int i = 0; i < 16; i++) begin
         drive(0, 0, 0, 0, 1, 4'(i));
         @(negedge Clk);
         n_total++; if (rdd0 !== 8'hA5 || rdv0 !== 1'b1) begin n_bad++; $display("FAIL init_read0 addr=%0d got=%h/%b exp=a5/1", i, rdd0, rdv0); end
         if (i > 0) begin
            n_total++; if (rdd1 !== 8'hA5 || rdv1 !== 1'b1) begin n_bad++; $display("FAIL init_read1 addr=%0d got=%h/%b exp=a5/1", i - 1, rdd1, rdv1); end
         end
         tick();
      end
      drive(0, 0, 0, 0, 0, 0);
      @(negedge Clk);
      n_total++; if (rdd1 !== 8'hA5 || rdv1 !== 1'b1) begin n_bad++; $display("FAIL init_read1 addr=15 got=%h/%b exp=a5/1", rdd1, rdv1); end
      tick();
   endtask

   task automatic test_wr_rd_lat1();
      drive(0, 1, 5, 8'h3C, 0, 0); @(negedge Clk); tick();
      drive(0, 0, 0, 0, 1, 5);
      @(negedge Clk);
      n_total++; if (rdv1 !== 1'b0) begin n_bad++; $display("FAIL lat1_early_valid got=%b exp=0", rdv1); end
      n_total++; if (rdd0 !== 8'h3C) begin n_bad++; $display("FAIL lat0_after_write got=%h exp=3c", rdd0); end
      tick();
      drive(0, 0, 0, 0, 0, 0);
      @(negedge Clk);
      n_total++; if (rdv1 !== 1'b1 || rdd1 !== 8'h3C) begin n_bad++; $display("FAIL lat1_read got=%h/%b exp=3c/1", rdd1, rdv1); end
      tick();
      @(negedge Clk);
      n_total++; if (rdv1 !== 1'b0 || rdd1 !== 8'h3C) begin n_bad++; $display("FAIL lat1_hold got=%h/%b exp=3c/0", rdd1, rdv1); end
      tick();
   endtask

   task automatic test_collision();
      drive(0, 1, 7, 8'h99, 1, 7);
      @(negedge Clk);
      n_total++; if (rdd0 !== 8'hA5) begin n_bad++; $display("FAIL coll_lat0_old got=%h exp=a5", rdd0); end
      tick();
      drive(0, 0, 0, 0, 0, 0);
      @(negedge Clk);
      n_total++; if (rdv1 !== 1'b1 || rdd1 !== 8'h99) begin n_bad++; $display("FAIL coll_write_first got=%h/%b exp=99/1", rdd1, rdv1); end
      tick();
   endtask

   task automatic test_lat0_old();
      drive(0, 1, 2, 8'h11, 1, 2);
      @(negedge Clk);
      n_total++; if (rdd0 !== 8'hA5 || rdv0 !== 1'b1) begin n_bad++; $display("FAIL lat0_same_cycle got=%h/%b exp=a5/1", rdd0, rdv0); end
      tick();
      drive(0, 0, 0, 0, 1, 2);
      @(negedge Clk);
      n_total++; if (rdd0 !== 8'h11) begin n_bad++; $display("FAIL lat0_next_cycle got=%h exp=11", rdd0); end
      n_total++; if (rdd1 !== 8'h11) begin n_bad++; $display("FAIL lat1_coll_addr2 got=%h exp=11", rdd1); end
      tick();
   endtask

   task automatic test_back_to_back();
      for (int i = 0; i < 16; i++) begin
         drive(0, 1, 4'(i), 8'(i * 17 + 3), 0, 0); @(negedge Clk); tick();
      end
      for (int i = 0; i < 16; i++) begin
         drive(0, 0, 0, 0, 1, 4'(i));
         @(negedge Clk);
         n_total++; if (rdd0 !== 8'(i * 17 + 3)) begin n_bad++; $display("FAIL b2b_lat0 addr=%0d got=%h exp=%h", i, rdd0, 8'(i * 17 + 3)); end
         if (i > 0) begin
            n_total++; if (rdv1 !== 1'b1 || rdd1 !== 8'((i - 1) * 17 + 3)) begin n_bad++; $display("FAIL b2b_lat1 addr=%0d got=%h/%b exp=%h/1", i - 1, rdd1, rdv1, 8'((i - 1) * 17 + 3)); end
         end
         tick();
      end
      drive(0, 0, 0, 0, 0, 0);
      @(negedge Clk);
      n_total++; if (rdv1 !== 1'b1 || rdd1 !== 8'(15 * 17 + 3)) begin n_bad++; $display("FAIL b2b_lat1 addr=15 got=%h/%b", rdd1, rdv1); end
      tick();
   endtask

   task automatic test_clear_ignore();
      drive(1, 0, 0, 0, 0, 0); tick();
      for (int k = 0; k < 16; k++) begin
         if (k == 0) drive(0, 1, 0, 8'hFF, 1, 0);
         else drive(0, 1, 4'($urandom_range(0, 15)), 8'($urandom), 1, 4'($urandom_range(0, 15)));
         @(negedge Clk);
         n_total++; if (rdv0 !== 1'b0 || rdv1 !== 1'b0 || rdy1 !== 1'b0) begin n_bad++; $display("FAIL clear_ignore cyc=%0d got v0=%b v1=%b rdy=%b exp 0/0/0", k, rdv0, rdv1, rdy1); end
         tick();
      end
      drive(0, 0, 0, 0, 1, 0);
      @(negedge Clk);
      n_total++; if (rdy1 !== 1'b1 || rdd0 !== 8'hA5 || rdv0 !== 1'b1) begin n_bad++; $display("FAIL clear_ignore_word0 got rdy=%b d0=%h v0=%b exp 1/a5/1", rdy1, rdd0, rdv0); end
      tick();
      drive(0, 0, 0, 0, 0, 0);
      @(negedge Clk);
      n_total++; if (rdd1 !== 8'hA5 || rdv1 !== 1'b1) begin n_bad++; $display("FAIL clear_ignore_word0_lat1 got=%h/%b exp=a5/1", rdd1, rdv1); end
      tick();
   endtask

   task automatic test_reset_midclear();
      drive(0, 1, 3, 8'h42, 0, 0); @(negedge Clk); tick();
      drive(0, 0, 0, 0, 1, 3);
      @(negedge Clk);
      n_total++; if (rdd0 !== 8'h42) begin n_bad++; $display("FAIL midclr_written got=%h exp=42", rdd0); end
      tick();
      drive(1, 0, 0, 0, 0, 0); tick();
      for (int k = 0; k < 6; k++) begin
         drive(0, 0, 0, 0, 0, 0);
         @(negedge Clk);
         n_total++; if (rdy1 !== 1'b0 || rdy0 !== 1'b0) begin n_bad++; $display("FAIL midclr_ready_low step=%0d got=%b/%b exp=0/0", k, rdy1, rdy0); end
         tick();
      end
      drive(1, 0, 0, 0, 0, 0); tick();
      for (int k = 0; k <= 16; k++) begin
         drive(0, 0, 0, 0, 0, 0);
         @(negedge Clk);
         n_total++; if (rdy1 !== (k >= 16) || rdy0 !== (k >= 16)) begin n_bad++; $display("FAIL midclr_ready cyc=%0d got=%b/%b exp=%b", k, rdy1, rdy0, (k >= 16)); end
         tick();
      end
      drive(0, 0, 0, 0, 1, 3);
      @(negedge Clk);
      n_total++; if (rdd0 !== 8'hA5) begin n_bad++; $display("FAIL midclr_word3_lat0 got=%h exp=a5", rdd0); end
      tick();
      drive(0, 0, 0, 0, 0, 0);
      @(negedge Clk);
      n_total++; if (rdd1 !== 8'hA5 || rdv1 !== 1'b1) begin n_bad++; $display("FAIL midclr_word3_lat1 got=%h/%b exp=a5/1", rdd1, rdv1); end
      tick();
   endtask

   task automatic test_random();
      logic rdy;
      for (int n = 0; n < 400; n++) begin
         drive(($urandom_range(0, 59) == 0), 1'($urandom), 4'($urandom_range(0, 15)), 8'($urandom),
               1'($urandom), 4'($urandom_range(0, 15)));
         if (($urandom_range(0, 3) == 0) && !Reset) WrAddr = RdAddr;
         @(negedge Clk);
         rdy = (m_cyc >= 16);
         n_total++; if (rdy1 !== rdy || rdy0 !== rdy) begin n_bad++; $display("FAIL rand_ready n=%0d got=%b/%b exp=%b", n, rdy1, rdy0, rdy); end
         n_total++; if (rdv1 !== m_v1 || rdd1 !== m_d1) begin n_bad++; $display("FAIL rand_lat1 n=%0d got=%h/%b exp=%h/%b", n, rdd1, rdv1, m_d1, m_v1); end
         n_total++; if (rdv0 !== (RdEn && rdy)) begin n_bad++; $display("FAIL rand_valid0 n=%0d got=%b exp=%b", n, rdv0, (RdEn && rdy)); end
         if (rdy) begin
            n_total++; if (rdd0 !== m_mem[RdAddr]) begin n_bad++; $display("FAIL rand_data0 n=%0d addr=%0d got=%h exp=%h", n, RdAddr, rdd0, m_mem[RdAddr]); end
         end
         tick();
      end
   endtask

   initial begin
      test_reset();
      test_wr_rd_lat1();
      test_collision();
      test_lat0_old();
      test_back_to_back();
      test_clear_ignore();
      test_reset_midclear();
      test_random();
      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end

endmodule
